// File: rtl/addr_data_router.sv
// rtl/addr_data_router.sv - joins addr/data channels into a FIFO and routes the head to local or forward port
// Optional per-port pop counters: define ADDR_DATA_ROUTER_PKT_COUNT_EN.

module addr_data_router #(
    parameter logic [3:0] LOCAL_ADDR = 4'd0,
    parameter int         DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_in_valid,
    output logic                     data_in_ready,
    input  logic [6:0]               data_in,
    input  logic                     addr_in_valid,
    output logic                     addr_in_ready,
    input  logic [3:0]               addr_in,
    output logic                     local_valid,
    input  logic                     local_ready,
    output logic [6:0]               local_data,
    output logic                     fwd_valid,
    input  logic                     fwd_ready,
    output logic [10:0]              fwd_pkt,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef ADDR_DATA_ROUTER_PKT_COUNT_EN
    ,
    output logic [7:0]               local_count,
    output logic [7:0]               fwd_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    // Entry layout matches fwd_pkt: {data[6:0], addr[3:0]}
    logic [10:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;

    logic        in_ready;
    logic        empty;
    logic        is_local;
    logic [10:0] head;
    logic        push;
    logic        pop;
    logic        local_pop;
    logic        fwd_pop;

    always_comb begin
        in_ready    = !reset && (occ_q < OW'(DEPTH));
        empty       = (occ_q == '0);
        head        = mem_q[rd_ptr_q];
        is_local    = (head[3:0] == LOCAL_ADDR);
        local_valid = !reset && !empty && is_local;
        fwd_valid   = !reset && !empty && !is_local;
        // Payloads are masked so they read as zero whenever nothing is presented
        local_data  = local_valid ? head[10:4] : '0;
        fwd_pkt     = fwd_valid ? head : '0;
        push        = data_in_valid && addr_in_valid && in_ready;
        local_pop   = local_valid && local_ready;
        fwd_pop     = fwd_valid && fwd_ready;
        pop         = local_pop || fwd_pop;
    end

    assign data_in_ready = in_ready;
    assign addr_in_ready = in_ready;
    assign occupancy     = occ_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        occ_d    = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: push is already blocked during reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {data_in, addr_in};
        end
    end

`ifdef ADDR_DATA_ROUTER_PKT_COUNT_EN
    logic [7:0] local_count_q, local_count_d;
    logic [7:0] fwd_count_q, fwd_count_d;

    always_comb begin
        local_count_d = local_count_q;
        fwd_count_d   = fwd_count_q;
        if (local_pop && (local_count_q != 8'hFF)) begin
            local_count_d = local_count_q + 8'd1;
        end
        if (fwd_pop && (fwd_count_q != 8'hFF)) begin
            fwd_count_d = fwd_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            local_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            local_count_q <= local_count_d;
            fwd_count_q   <= fwd_count_d;
        end
    end

    assign local_count = local_count_q;
    assign fwd_count   = fwd_count_q;
`endif

endmodule
